// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//   Single-clock stopwatch: centiseconds, seconds and minutes with run/pause,
//   clear and overflow. A clk-driven prescaler makes the centisecond tick.
//   Every carry is a clock enable; there are no derived clocks.
//
// Optional feature macro: STOPWATCH_LAP_EN (lap capture registers).
//   When it is undefined, the lap input is ignored and the lap outputs are tied to 0.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low, released synchronously
//   start_stop in   1-cycle pulse: toggle run/pause (ignored while saturated)
//   clear      in   1-cycle pulse: zero time, prescaler and ovf, stop
//   lap        in   1-cycle pulse: capture lap time (lap build only)
//   running    out  1 while counting
//   cs/sec/min out  binary time fields
//   sec_flag   out  1-cycle pulse when sec changes because of a cs carry
//   ovf        out  sticky overflow (wrap or saturation past the max time)
//   lap_cs/lap_sec/lap_min out  captured lap time
//   lap_valid  out  1-cycle pulse when the lap registers update
//   dbg_state  out  FSM state (00 paused, 01 running, 10 saturated)
//
// There is no valid/ready handshake. Every control input is a single-cycle
// pulse that is sampled on the next rising clk edge.
// -----------------------------------------------------------------------------
module stopwatch_core #(
  parameter int TICK_DIV = 500000,
  parameter int CS_MAX   = 99,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int WRAP_EN  = 1,
  localparam int CSW = (CS_MAX  > 0) ? $clog2(CS_MAX + 1)  : 1,
  localparam int SW  = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1,
  localparam int MW  = (MIN_MAX > 0) ? $clog2(MIN_MAX + 1) : 1,
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV)   : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_stop,
  input  logic           clear,
  input  logic           lap,
  output logic           running,
  output logic [CSW-1:0] cs,
  output logic [SW-1:0]  sec,
  output logic [MW-1:0]  min,
  output logic           sec_flag,
  output logic           ovf,
  output logic [CSW-1:0] lap_cs,
  output logic [SW-1:0]  lap_sec,
  output logic [MW-1:0]  lap_min,
  output logic           lap_valid,
  output logic [1:0]     dbg_state
);

  // The encoding lets running come directly from bit 0 of the state register.
  localparam logic [1:0] ST_PAUSE = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_SAT   = 2'b10;

  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CSW-1:0] CS_LAST  = CSW'(CS_MAX);
  localparam logic [SW-1:0]  SEC_LAST = SW'(SEC_MAX);
  localparam logic [MW-1:0]  MIN_LAST = MW'(MIN_MAX);

  logic [1:0]     state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [CSW-1:0] cs_q, cs_d;
  logic [SW-1:0]  sec_q, sec_d;
  logic [MW-1:0]  min_q, min_d;
  logic           flag_q, flag_d;
  logic           ovf_q, ovf_d;
  logic           tick;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cs_d    = cs_q;
    sec_d   = sec_q;
    min_d   = min_q;
    flag_d  = 1'b0;
    ovf_d   = ovf_q;
    tick    = (state_q == ST_RUN) && (presc_q == PRE_LAST);

    if (clear) begin
      // clear overrides start_stop and a tick in the same cycle
      state_d = ST_PAUSE;
      presc_d = '0;
      cs_d    = '0;
      sec_d   = '0;
      min_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      // The prescaler holds while paused, so a partial tick is kept across a pause.
      if (state_q == ST_RUN) presc_d = tick ? '0 : presc_q + PW'(1);

      // All carries resolve on the same edge as the tick.
      if (tick) begin
        if (cs_q != CS_LAST) begin
          cs_d = cs_q + CSW'(1);
        end else if (sec_q != SEC_LAST) begin
          cs_d   = '0;
          sec_d  = sec_q + SW'(1);
          flag_d = 1'b1;
        end else if (min_q != MIN_LAST) begin
          cs_d   = '0;
          sec_d  = '0;
          min_d  = min_q + MW'(1);
          flag_d = 1'b1;
        end else if (WRAP_EN != 0) begin
          cs_d   = '0;
          sec_d  = '0;
          min_d  = '0;
          flag_d = 1'b1;
          ovf_d  = 1'b1;
        end else begin
          // Saturate: hold the max time and lock out start_stop until clear.
          ovf_d   = 1'b1;
          state_d = ST_SAT;
        end
      end

      if (start_stop && (state_d != ST_SAT))
        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PAUSE;
      presc_q <= '0;
      cs_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cs_q    <= cs_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  assign running   = state_q[0];
  assign cs        = cs_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign sec_flag  = flag_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

`ifdef STOPWATCH_LAP_EN
  logic [CSW-1:0] lap_cs_q, lap_cs_d;
  logic [SW-1:0]  lap_sec_q, lap_sec_d;
  logic [MW-1:0]  lap_min_q, lap_min_d;
  logic           lap_valid_q, lap_valid_d;

  // The lap registers capture the post-update time, which is what the outputs show after the same edge.
  always_comb begin
    lap_cs_d    = lap_cs_q;
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_valid_d = 1'b0;
    if (clear) begin
      lap_cs_d  = '0;
      lap_sec_d = '0;
      lap_min_d = '0;
    end else if (lap) begin
      lap_cs_d    = cs_d;
      lap_sec_d   = sec_d;
      lap_min_d   = min_d;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_cs_q    <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_cs_q    <= lap_cs_d;
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_cs    = lap_cs_q;
  assign lap_sec   = lap_sec_q;
  assign lap_min   = lap_min_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_cs     = '0;
  assign lap_sec    = '0;
  assign lap_min    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule
